// File: rtl/rfalu_seq_pkg.sv
// Shared types and constants for the LEGv8 RF-ALU instruction sequencer.
// Holds opcode encodings, ALUOp codes, the FSM state type and the decoded control bundle.
package rfalu_seq_pkg;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;

   // X31 reads as zero, so writes to it are dropped.
   localparam logic [4:0]  XZR = 5'd31;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_PASSB = 2'b01,
      ALU_RTYPE = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      EXEC,
      WB
   } state_e;

   typedef struct packed {
      alu_op_e    alu_op;
      logic       alu_src_select;
      logic [4:0] read1;
      logic [4:0] read2;
      logic [4:0] write_reg;
      logic       writes_reg;
      logic       is_cbz;
   } ctrl_t;

   function automatic logic is_rtype(input logic [10:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
   endfunction

endpackage

// File: rtl/rfalu_seq_decode.sv
// Combinational LEGv8 decoder: instruction word to control bundle plus a legal flag.
// Unsupported encodings come out as an all-zero bundle with legal low.
module rfalu_seq_decode
   import rfalu_seq_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        legal
);

   // Shift amount / immediate bits do not steer control.
   logic unused_bits;
   assign unused_bits = ^instr[15:10];

   always_comb begin
      // NOTE: every output gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
      ctrl  = '0;
      legal = 1'b0;
      if (is_rtype(instr[31:21])) begin
         ctrl.alu_op     = ALU_RTYPE;
         ctrl.read1      = instr[9:5];
         ctrl.read2      = instr[20:16];
         ctrl.write_reg  = instr[4:0];
         ctrl.writes_reg = 1'b1;
         legal           = 1'b1;
      end else if (instr[31:22] == OP_ADDI) begin
         ctrl.alu_op         = ALU_ADD;
         ctrl.alu_src_select = 1'b1;
         ctrl.read1          = instr[9:5];
         ctrl.write_reg      = instr[4:0];
         ctrl.writes_reg     = 1'b1;
         legal               = 1'b1;
      end else if (instr[31:24] == OP_CBZ) begin
         ctrl.alu_op = ALU_PASSB;
         ctrl.read2  = instr[4:0];
         ctrl.is_cbz = 1'b1;
         legal       = 1'b1;
      end
   end

endmodule

// File: rtl/rfalu_seq.sv
// Multi-cycle sequencer (IDLE/DECODE/EXEC/WB) driving a LEGv8 register-file + ALU datapath.
// Define RFALU_SEQ_PERF_EN to add the retired_count output.
module rfalu_seq
   import rfalu_seq_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        zero,
   output logic [1:0]  alu_op,
   output logic [10:0] opcode_field,
   output logic [4:0]  read1,
   output logic [4:0]  read2,
   output logic [4:0]  write_reg,
   output logic        reg_write,
   output logic        alu_src_select,
   output logic        done_valid,
   output logic        branch_taken,
   output logic        illegal
`ifdef RFALU_SEQ_PERF_EN
   ,
   output logic [31:0] retired_count
`endif
);

   localparam logic [3:0] LAST_EXEC = 4'(EXEC_CYCLES - 1);

   state_e      state_q, state_d;
   logic        ready_q;
   logic [31:0] instr_q;
   logic [3:0]  exec_cnt_q;
   ctrl_t       ctrl_q, dec_ctrl;
   logic        dec_legal;
   logic        illegal_q;

   rfalu_seq_decode u_decode (
      .instr (instr_q),
      .ctrl  (dec_ctrl),
      .legal (dec_legal)
   );

   // Ready is registered so it stays low for the whole reset and rises one edge after release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (instr_valid && ready_q) state_d = DECODE;
         DECODE:  state_d = dec_legal ? EXEC : WB;
         EXEC:    if (exec_cnt_q == LAST_EXEC) state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exec_cnt_q <= '0;
      end else if (state_q == EXEC && state_d == EXEC) begin
         exec_cnt_q <= exec_cnt_q + 4'd1;
      end else begin
         exec_cnt_q <= '0;
      end
   end

   // NOTE: datapath registers are reset too, because every output must read zero during reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_q      <= '0;
         ctrl_q       <= '0;
         illegal_q    <= 1'b0;
         opcode_field <= '0;
      end else begin
         if (state_q == IDLE && instr_valid && ready_q) instr_q <= instr;
         if (state_q == DECODE) begin
            ctrl_q       <= dec_ctrl;
            illegal_q    <= ~dec_legal;
            opcode_field <= instr_q[31:21];
         end
      end
   end

   assign instr_ready    = ready_q;
   assign alu_op         = ctrl_q.alu_op;
   assign alu_src_select = ctrl_q.alu_src_select;
   assign read1          = ctrl_q.read1;
   assign read2          = ctrl_q.read2;
   assign write_reg      = ctrl_q.write_reg;

   always_comb begin
      done_valid   = 1'b0;
      reg_write    = 1'b0;
      branch_taken = 1'b0;
      illegal      = 1'b0;
      if (state_q == WB) begin
         done_valid   = 1'b1;
         reg_write    = ctrl_q.writes_reg && (ctrl_q.write_reg != XZR);
         branch_taken = ctrl_q.is_cbz && zero;
         illegal      = illegal_q;
      end
   end

`ifdef RFALU_SEQ_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retired_count <= '0;
      end else if (done_valid) begin
         retired_count <= retired_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rfalu_seq.sv
// Self-checking bench for rfalu_seq: scoreboarded instruction stream on an EXEC_CYCLES=1
// instance, plus an EXEC_CYCLES=4 instance for latency and mid-instruction reset.
module tb_rfalu_seq;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // EXEC_CYCLES = 1 instance
   logic        reset_n, instr_valid, zero;
   logic [31:0] instr;
   logic        instr_ready, reg_write, alu_src_select, done_valid, branch_taken, illegal;
   logic [1:0]  alu_op;
   logic [10:0] opcode_field;
   logic [4:0]  read1, read2, write_reg;
   logic [31:0] retired_count;

   // EXEC_CYCLES = 4 instance
   logic        d4_reset_n, d4_instr_valid, d4_zero;
   logic [31:0] d4_instr;
   logic        d4_instr_ready, d4_reg_write, d4_alu_src_select, d4_done_valid, d4_branch_taken, d4_illegal;
   logic [1:0]  d4_alu_op;
   logic [10:0] d4_opcode_field;
   logic [4:0]  d4_read1, d4_read2, d4_write_reg;
   logic [31:0] d4_retired_count;

   rfalu_seq #(.EXEC_CYCLES(1)) dut (
      .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .zero(zero), .alu_op(alu_op), .opcode_field(opcode_field),
      .read1(read1), .read2(read2), .write_reg(write_reg), .reg_write(reg_write),
      .alu_src_select(alu_src_select), .done_valid(done_valid), .branch_taken(branch_taken),
      .illegal(illegal)
`ifdef RFALU_SEQ_PERF_EN
      , .retired_count(retired_count)
`endif
   );

   rfalu_seq #(.EXEC_CYCLES(4)) dut4 (
      .clock(clock), .reset_n(d4_reset_n), .instr_valid(d4_instr_valid), .instr(d4_instr),
      .instr_ready(d4_instr_ready), .zero(d4_zero), .alu_op(d4_alu_op), .opcode_field(d4_opcode_field),
      .read1(d4_read1), .read2(d4_read2), .write_reg(d4_write_reg), .reg_write(d4_reg_write),
      .alu_src_select(d4_alu_src_select), .done_valid(d4_done_valid), .branch_taken(d4_branch_taken),
      .illegal(d4_illegal)
`ifdef RFALU_SEQ_PERF_EN
      , .retired_count(d4_retired_count)
`endif
   );

`ifndef RFALU_SEQ_PERF_EN
   assign retired_count    = '0;
   assign d4_retired_count = '0;
`endif

   // Expected completion; -1 marks a field the instruction leaves unspecified.
   typedef struct {
      string name;
      int    f[10];  // alu_op, alu_src, read1, read2, write_reg, reg_write, branch, illegal, opcode, cycle
   } exp_t;

   exp_t  sb[$];
   bit    mon_en = 1'b0;
   string fld[10] = '{"alu_op", "alu_src_select", "read1", "read2", "write_reg",
                      "reg_write", "branch_taken", "illegal", "opcode_field", "done_cycle"};

   function automatic exp_t mk(input string n, input logic [31:0] w,
                               input int aop, src, r1, r2, wr, rw, br, il);
      exp_t e;
      logic [10:0] opc;
      opc    = w[31:21];
      e.name = n;
      e.f    = '{aop, src, r1, r2, wr, rw, br, il, int'(opc), 0};
      return e;
   endfunction

   // Scoreboard monitor for the EXEC_CYCLES=1 instance.
   always @(negedge clock) begin
      exp_t        e;
      logic [31:0] act[10];
      if (mon_en) begin
         if (done_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done_valid=1 at cycle %0d, scoreboard empty", cyc);
            end else begin
               e      = sb.pop_front();
               act[0] = 32'(alu_op);         act[1] = 32'(alu_src_select);
               act[2] = 32'(read1);          act[3] = 32'(read2);
               act[4] = 32'(write_reg);      act[5] = 32'(reg_write);
               act[6] = 32'(branch_taken);   act[7] = 32'(illegal);
               act[8] = 32'(opcode_field);   act[9] = 32'(cyc);
               for (int i = 0; i < 10; i++) begin
                  if (e.f[i] >= 0) begin
                     checks++;
                     if (act[i] !== 32'(e.f[i])) begin
                        errors++;
                        $display("FAIL %s.%s: got %0d, want %0d", e.name, fld[i], act[i], e.f[i]);
                     end
                  end
               end
            end
         end else begin
            checks++;
            if ({reg_write, branch_taken, illegal} !== 3'b000) begin
               errors++;
               $display("FAIL quiet_outside_wb: cycle %0d reg_write/branch/illegal=%b, want 000",
                        cyc, {reg_write, branch_taken, illegal});
            end
         end
      end
   end

   // Offer one instruction; instr_valid is left high for the caller to drop.
   task automatic send(input logic [31:0] w, input exp_t e, input int lat, output int k);
      int   n = 0;
      exp_t x = e;
      @(negedge clock);
      instr       = w;
      instr_valid = 1'b1;
      while (instr_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      k = cyc;
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL %s_accept: instr_ready=%b after %0d cycles, want 1", e.name, instr_ready, n);
      end else begin
         x.f[9] = k + 2 + lat;
         sb.push_back(x);
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      instr_valid = 1'b0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d completions outstanding, want 0", tag, sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; instr_valid = 1'b0; instr = '0; zero = 1'b0;
      d4_reset_n = 1'b0; d4_instr_valid = 1'b0; d4_instr = '0; d4_zero = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({instr_ready, done_valid, reg_write, branch_taken, illegal, alu_src_select,
           alu_op, opcode_field, read1, read2, write_reg} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b done=%b rw=%b alu_op=%b opc=%h r1=%0d r2=%0d wr=%0d, want all 0",
                  instr_ready, done_valid, reg_write, alu_op, opcode_field, read1, read2, write_reg);
      end
      checks++;
      if (d4_instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_d4: got %b, want 0", d4_instr_ready);
      end
`ifdef RFALU_SEQ_PERF_EN
      checks++;
      if (retired_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_retired: got %0d, want 0", retired_count);
      end
`endif
      reset_n    = 1'b1;
      d4_reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, want 1", instr_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_add;
      int k;
      send(32'h8B020023, mk("add", 32'h8B020023, 2, 0, 1, 2, 3, 1, 0, 0), 1, k);
      drain("add");
   endtask

   task automatic test_addi;
      int k;
      send(32'h91002824, mk("addi", 32'h91002824, 0, 1, 1, -1, 4, 1, 0, 0), 1, k);
      drain("addi");
   endtask

   task automatic test_cbz;
      int k;
      zero = 1'b1;
      send(32'hB4000005, mk("cbz_taken", 32'hB4000005, 1, 0, -1, 5, -1, 0, 1, 0), 1, k);
      drain("cbz_taken");
      zero = 1'b0;
      send(32'hB4000005, mk("cbz_not_taken", 32'hB4000005, 1, 0, -1, 5, -1, 0, 0, 0), 1, k);
      drain("cbz_not_taken");
   endtask

   task automatic test_illegal;
      int k;
      send(32'h00000000, mk("illegal_zero", 32'h00000000, -1, -1, -1, -1, -1, 0, 0, 1), 0, k);
      drain("illegal_zero");
      // ADD with bit 21 flipped is not a supported opcode.
      send(32'h8B220023, mk("illegal_near_add", 32'h8B220023, -1, -1, -1, -1, -1, 0, 0, 1), 0, k);
      drain("illegal_near_add");
   endtask

   task automatic test_xzr;
      int k;
      send(32'h8B02003F, mk("add_xzr", 32'h8B02003F, 2, 0, 1, 2, 31, 0, 0, 0), 1, k);
      drain("add_xzr");
   endtask

   task automatic test_rtype_ops;
      logic [10:0] ops[3] = '{11'b11001011000, 11'b10001010000, 11'b10101010000};
      string       nm[3]  = '{"sub", "and", "orr"};
      logic [31:0] w;
      int          k;
      for (int i = 0; i < 3; i++) begin
         w = {ops[i], 5'(9 + i), 6'd0, 5'(20 + i), 5'(7 + i)};
         send(w, mk(nm[i], w, 2, 0, 20 + i, 9 + i, 7 + i, 1, 0, 0), 1, k);
      end
      drain("rtype_ops");
   endtask

   task automatic test_back_to_back;
      logic [31:0] w, base;
      int          k, k_first, k_last;
      base = retired_count;
      for (int i = 0; i < 10; i++) begin
         w = {11'b10001011000, 5'(i + 2), 6'd0, 5'(i), 5'(i + 1)};
         send(w, mk("b2b_add", w, 2, 0, i, i + 2, i + 1, 1, 0, 0), 1, k);
         if (i == 0) k_first = k;
         k_last = k;
      end
      drain("b2b");
      checks++;
      if (k_last - k_first != 36) begin
         errors++;
         $display("FAIL b2b_spacing: 10 transfers spanned %0d cycles, want 36", k_last - k_first);
      end
`ifdef RFALU_SEQ_PERF_EN
      checks++;
      if (retired_count - base !== 32'd10) begin
         errors++;
         $display("FAIL b2b_retired: got %0d, want 10", retired_count - base);
      end
`endif
   endtask

   task automatic d4_transfer(input logic [31:0] w, output int k);
      int n = 0;
      @(negedge clock);
      d4_instr       = w;
      d4_instr_valid = 1'b1;
      while (d4_instr_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      k = cyc;
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL d4_accept: instr_ready=%b after %0d cycles, want 1", d4_instr_ready, n);
      end
      @(posedge clock);
      #1;
      d4_instr_valid = 1'b0;
   endtask

   task automatic test_exec4;
      int k, n = 0;
      d4_transfer(32'h8B020023, k);
      while (d4_done_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (d4_done_valid !== 1'b1 || cyc != k + 6) begin
         errors++;
         $display("FAIL exec4_latency: done at cycle %0d (done=%b), want %0d", cyc, d4_done_valid, k + 6);
      end
      checks++;
      if ({d4_reg_write, d4_alu_op, d4_write_reg} !== {1'b1, 2'b10, 5'd3}) begin
         errors++;
         $display("FAIL exec4_wb: rw=%b alu_op=%b wr=%0d, want 1 10 3", d4_reg_write, d4_alu_op, d4_write_reg);
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_mid_reset;
      int k, n = 0, pulses = 0;
      d4_transfer(32'h8B020023, k);
      while (cyc < k + 3 && n < 20) begin
         @(negedge clock);
         n++;
      end
      d4_reset_n = 1'b0;
      #1;
      checks++;
      if ({d4_instr_ready, d4_done_valid, d4_reg_write, d4_alu_op, d4_read1, d4_read2,
           d4_write_reg, d4_opcode_field, d4_alu_src_select} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: ready=%b done=%b rw=%b alu_op=%b opc=%h, want all 0",
                  d4_instr_ready, d4_done_valid, d4_reg_write, d4_alu_op, d4_opcode_field);
      end
      @(negedge clock);
      if (d4_done_valid || d4_reg_write) pulses++;
      d4_reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (d4_instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: got %b one cycle after release, want 1", d4_instr_ready);
      end
      for (int i = 0; i < 8; i++) begin
         if (d4_done_valid !== 1'b0 || d4_reg_write !== 1'b0) pulses++;
         @(negedge clock);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midreset_no_pulse: %0d cycles with done_valid/reg_write, want 0", pulses);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_addi;
      test_cbz;
      test_illegal;
      test_xzr;
      test_rtype_ops;
      test_back_to_back;
      test_exec4;
      test_mid_reset;
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
